// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring integer divider, one quotient bit per clock.
// Signed/unsigned per operation, start/done handshake, divide-by-zero detection.
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] count;
   logic             zero_flag, neg_quo, neg_rem;
   logic [WIDTH-1:0] rem_mag, quo_mag, dvs_mag;
   logic [WIDTH:0]   shifted, trial;
   logic             accept, last_iter, dvd_neg, dvs_neg;

   function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] val);
      return neg ? (~val + WIDTH'(1)) : val;
   endfunction

   assign accept    = (state == IDLE) && start;
   assign last_iter = (count == CNT_W'(1));
   assign dvd_neg   = is_signed && dividend[WIDTH-1];
   assign dvs_neg   = is_signed && divisor[WIDTH-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (divisor == '0) ? FIX : RUN;
         RUN:     if (last_iter) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count       <= '0;
         zero_flag   <= 1'b0;
         neg_quo     <= 1'b0;
         neg_rem     <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= (state == FIX);
         if (accept) begin
            count     <= CNT_W'(WIDTH);
            zero_flag <= (divisor == '0);
            neg_quo   <= dvd_neg ^ dvs_neg;
            neg_rem   <= dvd_neg;
         end else if (state == RUN) begin
            count <= count - CNT_W'(1);
         end
         // Sign fix-up: quotient truncates toward zero, remainder follows the dividend
         if (state == FIX) begin
            quotient    <= zero_flag ? '1 : neg_if(neg_quo, quo_mag);
            remainder   <= neg_if(neg_rem, rem_mag);
            div_by_zero <= zero_flag;
         end
      end
   end

   assign shifted = {rem_mag, quo_mag[WIDTH-1]};
   assign trial   = shifted - {1'b0, dvs_mag};

   // On a zero divisor the dividend magnitude parks in rem_mag so FIX restores it unchanged
   always_ff @(posedge clk) begin
      if (accept) begin
         quo_mag <= neg_if(dvd_neg, dividend);
         dvs_mag <= neg_if(dvs_neg, divisor);
         rem_mag <= (divisor == '0) ? neg_if(dvd_neg, dividend) : '0;
      end else if (state == RUN) begin
         rem_mag <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
         quo_mag <= {quo_mag[WIDTH-2:0], ~trial[WIDTH]};
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed table, handshake sequences and randomized
// operations on 32- and 8-bit instances against a truncating-division model.
module tb_seq_divider;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        start32, sgn32, busy32, done32, dbz32;
   logic [31:0] dvd32, dvs32, quo32, rem32;
   logic        start8, sgn8, busy8, done8, dbz8;
   logic [7:0]  dvd8, dvs8, quo8, rem8;

   seq_divider #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(reset), .start(start32), .is_signed(sgn32),
      .dividend(dvd32), .divisor(dvs32), .busy(busy32), .done(done32),
      .quotient(quo32), .remainder(rem32), .div_by_zero(dbz32)
   );

   seq_divider #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .is_signed(sgn8),
      .dividend(dvd8), .divisor(dvs8), .busy(busy8), .done(done8),
      .quotient(quo8), .remainder(rem8), .div_by_zero(dbz8)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        z;
      int          lat;
   } vec_t;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Truncating division on w-bit operands using plain 64-bit arithmetic
   function automatic void model(input int w, input logic s, input longint a, input longint b,
                                 output longint q, output longint r, output longint z);
      longint m, sa, sb;
      m  = (longint'(1) << w) - 1;
      sa = a & m;
      sb = b & m;
      if (s && (((sa >> (w - 1)) & 1) == 1)) sa = sa - (longint'(1) << w);
      if (s && (((sb >> (w - 1)) & 1) == 1)) sb = sb - (longint'(1) << w);
      if (sb == 0) begin
         q = m;
         r = a & m;
         z = 1;
      end else begin
         q = (sa / sb) & m;
         r = (sa % sb) & m;
         z = 0;
      end
   endfunction

   task automatic op32(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic z,
                       output int lat, output int bcnt);
      @(negedge clk);
      start32 = 1'b1; sgn32 = s; dvd32 = a; dvs32 = b;
      @(posedge clk);
      #1;
      start32 = 1'b0; sgn32 = 1'($urandom); dvd32 = $urandom; dvs32 = $urandom;
      lat  = 0;
      bcnt = busy32 ? 1 : 0;
      while (lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         if (done32) break;
         if (busy32) bcnt++;
      end
      q = quo32; r = rem32; z = dbz32;
   endtask

   task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                      output logic [7:0] q, output logic [7:0] r, output logic z,
                      output int lat);
      @(negedge clk);
      start8 = 1'b1; sgn8 = s; dvd8 = a; dvs8 = b;
      @(posedge clk);
      #1;
      start8 = 1'b0; sgn8 = 1'($urandom); dvd8 = 8'($urandom); dvs8 = 8'($urandom);
      lat = 0;
      while (lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (done8) break;
      end
      q = quo8; r = rem8; z = dbz8;
   endtask

   initial begin
      vec_t        tbl [10];
      logic [31:0] q, r, a, b;
      logic [7:0]  q8, r8, a8, b8;
      logic [7:0]  edge8 [9];
      logic        z, seen;
      int          lat, bcnt, nd;
      longint      eq, er, ez;

      reset = 1'b1;
      start32 = 1'b0; sgn32 = 1'b0; dvd32 = '0; dvs32 = '0;
      start8  = 1'b0; sgn8  = 1'b0; dvd8  = '0; dvs8  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", busy32, 0);
      check("reset_done", done32, 0);
      check("reset_quo", quo32, 0);
      check("reset_rem", rem32, 0);
      check("reset_dbz", dbz32, 0);
      @(negedge clk);
      reset = 1'b0;

      tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
      tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 33};
      tbl[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 33};
      tbl[3] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0, 33};
      tbl[4] = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1};
      tbl[5] = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 33};
      tbl[6] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 33};
      tbl[7] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 33};
      tbl[8] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1, 1};
      tbl[9] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 33};

      // Consecutive calls start in the done cycle, so these also run back-to-back
      for (int i = 0; i < 10; i++) begin
         op32(tbl[i].s, tbl[i].a, tbl[i].b, q, r, z, lat, bcnt);
         check($sformatf("tbl%0d_quo", i), q, tbl[i].q);
         check($sformatf("tbl%0d_rem", i), r, tbl[i].r);
         check($sformatf("tbl%0d_dbz", i), z, tbl[i].z);
         check($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
         check($sformatf("tbl%0d_busy_cycles", i), bcnt, tbl[i].lat);
      end

      @(posedge clk);
      #1;
      check("done_single_pulse", done32, 0);
      check("idle_after_done", busy32, 0);

      // Start pulsed mid-RUN with other operands must be ignored
      @(negedge clk);
      start32 = 1'b1; sgn32 = 1'b0; dvd32 = 32'd1000; dvs32 = 32'd10;
      @(posedge clk);
      #1;
      start32 = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      start32 = 1'b1; sgn32 = 1'b1; dvd32 = 32'd77; dvs32 = 32'd0;
      @(negedge clk);
      start32 = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(posedge clk);
         #1;
         if (done32) begin
            seen = 1'b1;
            break;
         end
      end
      check("midrun_done_seen", seen, 1);
      check("midrun_quo", quo32, 100);
      check("midrun_rem", rem32, 0);
      check("midrun_dbz", dbz32, 0);
      nd = 0;
      for (int n = 0; n < 50; n++) begin
         @(posedge clk);
         #1;
         if (done32) nd++;
      end
      check("midrun_no_queued_done", nd, 0);

      // Reset at iteration 10 aborts the operation
      @(negedge clk);
      start32 = 1'b1; sgn32 = 1'b0; dvd32 = 32'd12345678; dvs32 = 32'd3;
      @(posedge clk);
      #1;
      start32 = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("abort_busy", busy32, 0);
      check("abort_done", done32, 0);
      check("abort_quo", quo32, 0);
      check("abort_rem", rem32, 0);
      check("abort_dbz", dbz32, 0);
      @(negedge clk);
      reset = 1'b0;
      nd = 0;
      for (int n = 0; n < 50; n++) begin
         @(posedge clk);
         #1;
         if (done32) nd++;
      end
      check("abort_no_done", nd, 0);
      op32(1'b0, 32'd123456789, 32'd1000, q, r, z, lat, bcnt);
      check("after_abort_quo", q, 123456);
      check("after_abort_rem", r, 789);
      check("after_abort_latency", lat, 33);

      for (int i = 0; i < 150; i++) begin
         logic s;
         s = 1'($urandom);
         a = $urandom;
         case (i % 4)
            0:       b = 32'($urandom_range(0, 15));
            1:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         op32(s, a, b, q, r, z, lat, bcnt);
         model(32, s, longint'(a), longint'(b), eq, er, ez);
         check($sformatf("rnd32_%0d_quo", i), q, eq);
         check($sformatf("rnd32_%0d_rem", i), r, er);
         check($sformatf("rnd32_%0d_dbz", i), z, ez);
         check($sformatf("rnd32_%0d_latency", i), lat, (b == 0) ? 1 : 33);
      end

      edge8 = '{8'h00, 8'h01, 8'h02, 8'h07, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 9; j++) begin
               op8(1'(m), edge8[i], edge8[j], q8, r8, z, lat);
               model(8, 1'(m), longint'(edge8[i]), longint'(edge8[j]), eq, er, ez);
               check($sformatf("edge8_m%0d_%0h_%0h_quo", m, edge8[i], edge8[j]), q8, eq);
               check($sformatf("edge8_m%0d_%0h_%0h_rem", m, edge8[i], edge8[j]), r8, er);
               check($sformatf("edge8_m%0d_%0h_%0h_dbz", m, edge8[i], edge8[j]), z, ez);
               check($sformatf("edge8_m%0d_%0h_%0h_latency", m, edge8[i], edge8[j]), lat,
                     (edge8[j] == 0) ? 1 : 9);
            end
         end
      end

      for (int i = 0; i < 300; i++) begin
         logic s;
         s  = 1'($urandom);
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         op8(s, a8, b8, q8, r8, z, lat);
         model(8, s, longint'(a8), longint'(b8), eq, er, ez);
         check($sformatf("rnd8_%0d_quo", i), q8, eq);
         check($sformatf("rnd8_%0d_rem", i), r8, er);
         check($sformatf("rnd8_%0d_dbz", i), z, ez);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
